// File: rtl/ans_symbol_model.sv
// ans_symbol_model
//   Frequency-model stage in front of the ANS encoder. A per-symbol count
//   table is written over a config handshake (index order 0..NSYM-1), then a
//   cumulative table and total are built one entry per enabled cycle. In RUN,
//   raw symbols are turned into (s_count, s_cumulative, total_count) triples
//   through a one-deep registered output stage.
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   ena             : global enable; low freezes all state, drops both readies
//   cfg_clear       : discard table, return to LOAD
//   cfg_count/vld/rdy : table write channel
//   table_rdy       : cumulative table built, lookups enabled
//   sym_in/vld/rdy  : symbol input channel
//   s_count, s_cumulative, total_count, out_vld, out_rdy : output triple channel
//   err_zero        : sticky, a zero-count symbol was presented
//   dbg_state       : current FSM state (LOAD=0, BUILD=1, RUN=2)
//
// Handshake rule for every channel: a transfer happens on a rising edge where
// both valid and ready are high; the producer holds valid and data stable
// until that edge, and ready may depend combinationally on the consumer side.

module ans_symbol_model #(
  parameter int SYM_WIDTH = 4,
  parameter int CNT_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic                           cfg_clear,
  input  logic [CNT_WIDTH-1:0]           cfg_count,
  input  logic                           cfg_vld,
  output logic                           cfg_rdy,
  output logic                           table_rdy,
  input  logic [SYM_WIDTH-1:0]           sym_in,
  input  logic                           sym_vld,
  output logic                           sym_rdy,
  output logic [CNT_WIDTH-1:0]           s_count,
  output logic [SYM_WIDTH+CNT_WIDTH-1:0] s_cumulative,
  output logic [SYM_WIDTH+CNT_WIDTH-1:0] total_count,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic                           err_zero,
  output logic [1:0]                     dbg_state
);

  localparam int NSYM = 1 << SYM_WIDTH;
  localparam int CW   = SYM_WIDTH + CNT_WIDTH;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_BUILD = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [SYM_WIDTH-1:0] LAST_IDX = SYM_WIDTH'(NSYM - 1);

  logic [1:0]           state;
  logic [SYM_WIDTH-1:0] ptr;
  logic [SYM_WIDTH-1:0] idx;
  logic [CW-1:0]        sum;
  logic [CNT_WIDTH-1:0] count_mem [NSYM];
  logic [CW-1:0]        cum_mem   [NSYM];

  logic                 sym_hs;
  logic [CNT_WIDTH-1:0] sel_cnt;
  logic [CW-1:0]        sel_cum;
  logic [CW-1:0]        build_next;

  assign dbg_state = state;

  assign cfg_rdy = ena & (state == ST_LOAD);
  assign sym_rdy = ena & (state == ST_RUN) & (~out_vld | out_rdy);
  assign sym_hs  = sym_vld & sym_rdy;

  assign sel_cnt    = count_mem[sym_in];
  assign sel_cum    = cum_mem[sym_in];
  // Running sum plus the entry being folded in; CW bits cannot overflow.
  assign build_next = sum + CW'(count_mem[idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_LOAD;
      ptr          <= '0;
      idx          <= '0;
      sum          <= '0;
      table_rdy    <= 1'b0;
      total_count  <= '0;
      err_zero     <= 1'b0;
      out_vld      <= 1'b0;
      s_count      <= '0;
      s_cumulative <= '0;
      for (int i = 0; i < NSYM; i++) begin
        count_mem[i] <= '0;
        cum_mem[i]   <= '0;
      end
    end else if (cfg_clear) begin
      // Table contents are left as-is; a reload overwrites every entry.
      state       <= ST_LOAD;
      ptr         <= '0;
      idx         <= '0;
      out_vld     <= 1'b0;
      table_rdy   <= 1'b0;
      total_count <= '0;
      err_zero    <= 1'b0;
    end else if (ena) begin
      case (state)
        ST_LOAD: begin
          if (cfg_vld) begin
            count_mem[ptr] <= cfg_count;
            ptr            <= ptr + 1'b1;
            if (ptr == LAST_IDX) begin
              state <= ST_BUILD;
              idx   <= '0;
              sum   <= '0;
            end
          end
        end
        ST_BUILD: begin
          cum_mem[idx] <= sum;
          sum          <= build_next;
          idx          <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            total_count <= build_next;
            table_rdy   <= 1'b1;
            state       <= ST_RUN;
          end
        end
        default: ;
      endcase

      // Output register: a taken triple retires; a new accept (below) wins
      // over the retire so that back-to-back transfers have no bubble.
      if (out_vld && out_rdy) begin
        out_vld <= 1'b0;
      end
      if (sym_hs) begin
        if (sel_cnt != '0) begin
          s_count      <= sel_cnt;
          s_cumulative <= sel_cum;
          out_vld      <= 1'b1;
        end else begin
          // Zero-probability symbol cannot be encoded: drop it, flag it.
          err_zero <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ans_symbol_model.sv
module tb_ans_symbol_model;

  localparam int SW   = 4;
  localparam int CNTW = 4;
  localparam int NSYM = 16;
  localparam int CW   = SW + CNTW;
  localparam int W    = CNTW + 2 * CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, ena, cfg_clear, cfg_vld, sym_vld, out_rdy;
  logic [CNTW-1:0] cfg_count;
  logic [SW-1:0]   sym_in;
  logic            cfg_rdy, table_rdy, sym_rdy, out_vld, err_zero;
  logic [CNTW-1:0] s_count;
  logic [CW-1:0]   s_cumulative, total_count;
  logic [1:0]      dbg_state;

  ans_symbol_model #(.SYM_WIDTH(SW), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .cfg_clear(cfg_clear),
    .cfg_count(cfg_count), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
    .table_rdy(table_rdy), .sym_in(sym_in), .sym_vld(sym_vld),
    .sym_rdy(sym_rdy), .s_count(s_count), .s_cumulative(s_cumulative),
    .total_count(total_count), .out_vld(out_vld), .out_rdy(out_rdy),
    .err_zero(err_zero), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0]    exp_q[$];
  logic [CNTW-1:0] m_cnt [NSYM];
  logic [CW-1:0]   m_cum [NSYM];
  logic [CW-1:0]   m_total;
  logic            m_err;

  typedef struct {
    logic [SW-1:0]   sym;
    logic            vld;
    logic            exp_vld;
    logic [CNTW-1:0] exp_cnt;
    logic [CW-1:0]   exp_cum;
    logic            exp_err;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cumulative = prefix sum of counts, total = sum of all counts.
  function automatic void build_model();
    int s;
    s = 0;
    for (int i = 0; i < NSYM; i++) begin
      m_cum[i] = CW'(s);
      s += int'(m_cnt[i]);
    end
    m_total = CW'(s);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ena = 1'b1; cfg_clear = 1'b0; cfg_vld = 1'b0; cfg_count = '0;
    sym_vld = 1'b0; sym_in = '0; out_rdy = 1'b0;
  endtask

  task automatic load_entries(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          cfg_vld = 1'b0;
          step();
        end
      end
      cfg_vld = 1'b1;
      cfg_count = m_cnt[i];
      @(negedge clk);
      chk("cfg_rdy_load", cfg_rdy, 1);
      step();
    end
    cfg_vld = 1'b0;
  endtask

  task automatic wait_table(output int n);
    n = 0;
    while (!table_rdy && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("table_rdy_timeout", table_rdy, 1);
  endtask

  task automatic run_vectors();
    for (int v = 0; v < 6; v++) begin
      sym_in = vecs[v].sym;
      sym_vld = vecs[v].vld;
      out_rdy = 1'b1;
      @(negedge clk);
      chk("vec_sym_rdy", sym_rdy, 1);
      step();
      chk("vec_out_vld", out_vld, vecs[v].exp_vld);
      if (vecs[v].exp_vld) begin
        chk("vec_s_count", s_count, vecs[v].exp_cnt);
        chk("vec_s_cum", s_cumulative, vecs[v].exp_cum);
        chk("vec_total", total_count, 19);
      end
      chk("vec_err_zero", err_zero, vecs[v].exp_err);
    end
    sym_vld = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_vld"}, out_vld, 0);
    chk({tag, "_table_rdy"}, table_rdy, 0);
    chk({tag, "_err_zero"}, err_zero, 0);
    chk({tag, "_total"}, total_count, 0);
    chk({tag, "_cfg_rdy"}, cfg_rdy, 1);
    chk({tag, "_sym_rdy"}, sym_rdy, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    logic exp_rdy;

    idle_inputs();
    rst = 1'b1;
    #1;
    check_reset_values("reset");
    chk("reset_s_count", s_count, 0);
    chk("reset_s_cum", s_cumulative, 0);
    step();
    rst = 1'b0;
    step();

    // Plan table: all 1 except sym3 = 5, sym7 = 0 -> total 19.
    for (int i = 0; i < NSYM; i++) m_cnt[i] = 4'd1;
    m_cnt[3] = 4'd5;
    m_cnt[7] = 4'd0;
    vecs[0] = '{sym: 4'd4, vld: 1'b1, exp_vld: 1'b1, exp_cnt: 4'd1, exp_cum: 8'd8,  exp_err: 1'b0};
    vecs[1] = '{sym: 4'd8, vld: 1'b1, exp_vld: 1'b1, exp_cnt: 4'd1, exp_cum: 8'd11, exp_err: 1'b0};
    vecs[2] = '{sym: 4'd3, vld: 1'b1, exp_vld: 1'b1, exp_cnt: 4'd5, exp_cum: 8'd3,  exp_err: 1'b0};
    vecs[3] = '{sym: 4'd7, vld: 1'b1, exp_vld: 1'b0, exp_cnt: 4'd0, exp_cum: 8'd0,  exp_err: 1'b1};
    vecs[4] = '{sym: 4'd0, vld: 1'b1, exp_vld: 1'b1, exp_cnt: 4'd1, exp_cum: 8'd0,  exp_err: 1'b1};
    vecs[5] = '{sym: 4'd0, vld: 1'b0, exp_vld: 1'b0, exp_cnt: 4'd0, exp_cum: 8'd0,  exp_err: 1'b1};

    load_entries(NSYM, 1'b0);
    chk("build_cfg_rdy", cfg_rdy, 0);
    wait_table(n);
    chk("build_latency", n, 16);
    chk("plan_total", total_count, 19);
    run_vectors();

    // Backpressure: sym5 held in the output while sym6 waits 5 cycles.
    sym_vld = 1'b1; sym_in = 4'd5; out_rdy = 1'b0;
    step();
    sym_in = 4'd6;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_sym_rdy", sym_rdy, 0);
      step();
      chk("bp_out_vld", out_vld, 1);
      chk("bp_s_count", s_count, 1);
      chk("bp_s_cum", s_cumulative, 9);
    end
    out_rdy = 1'b1;
    step();
    chk("bp_next_vld", out_vld, 1);
    chk("bp_next_cum", s_cumulative, 10);
    sym_vld = 1'b0;
    step();
    chk("bp_drain_vld", out_vld, 0);

    // ena dropped 3 cycles mid-BUILD: table identical, 3 cycles late.
    cfg_clear = 1'b1;
    step();
    cfg_clear = 1'b0;
    load_entries(NSYM, 1'b0);
    for (int c = 0; c < 5; c++) step();
    ena = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ena_cfg_rdy", cfg_rdy, 0);
      step();
    end
    chk("ena_build_not_done", table_rdy, 0);
    ena = 1'b1;
    wait_table(n);
    chk("ena_build_latency", n + 8, 19);
    run_vectors();

    // ena low while a triple is pending: held, out_rdy ignored.
    sym_vld = 1'b1; sym_in = 4'd3; out_rdy = 1'b0;
    step();
    sym_vld = 1'b0; ena = 1'b0; out_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_sym_rdy", sym_rdy, 0);
      step();
      chk("hold_out_vld", out_vld, 1);
      chk("hold_s_count", s_count, 5);
      chk("hold_s_cum", s_cumulative, 3);
    end
    ena = 1'b1;
    step();
    chk("hold_release_vld", out_vld, 0);

    // cfg_clear with a pending triple, then rst mid-load.
    sym_vld = 1'b1; sym_in = 4'd4; out_rdy = 1'b0;
    step();
    chk("pre_clear_vld", out_vld, 1);
    sym_vld = 1'b0;
    cfg_clear = 1'b1;
    step();
    cfg_clear = 1'b0;
    check_reset_values("clear");
    load_entries(5, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_values("rst_mid_load");
    step();
    rst = 1'b0;
    step();

    // Randomized rounds against the prefix-sum model and expected queue.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NSYM; i++)
        m_cnt[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : CNTW'($urandom_range(1, 15));
      build_model();
      m_err = 1'b0;
      exp_q.delete();
      load_entries(NSYM, 1'b1);
      wait_table(n);
      chk("rand_build_latency", n, 16);
      chk("rand_total", total_count, 32'(m_total));
      for (int c = 0; c < 300; c++) begin
        ena = ($urandom_range(0, 9) != 0);
        sym_vld = 1'($urandom_range(0, 1));
        sym_in = SW'($urandom_range(0, NSYM - 1));
        out_rdy = ($urandom_range(0, 3) != 0);
        exp_rdy = ena && (exp_q.size() == 0 || out_rdy);
        @(negedge clk);
        chk("rand_sym_rdy", sym_rdy, 32'(exp_rdy));
        if (ena) begin
          if (exp_q.size() != 0 && out_rdy) void'(exp_q.pop_front());
          if (sym_vld && exp_rdy) begin
            if (m_cnt[sym_in] != 0) exp_q.push_back({m_cnt[sym_in], m_cum[sym_in], m_total});
            else m_err = 1'b1;
          end
        end
        step();
        chk("rand_out_vld", out_vld, 32'(exp_q.size() != 0));
        if (exp_q.size() != 0)
          chk("rand_triple", 32'({s_count, s_cumulative, total_count}), 32'(exp_q[0]));
        chk("rand_err_zero", err_zero, 32'(m_err));
      end
      // Asynchronous reset mid-stream clears everything before any edge.
      idle_inputs();
      rst = 1'b1;
      #1;
      check_reset_values("rand_rst");
      step();
      rst = 1'b0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
